// File: rtl/activity_tracker_if.sv
// Bundles the tracker's two inputs and its display statistics.
// The tracker is the slave; the stimulus/display side is the master.
interface activity_tracker_if;
    logic        pulse;
    logic        secondclk;
    logic [13:0] total_steps;
    logic [6:0]  dist_tenths;
    logic [3:0]  early_secs;
    logic [15:0] high_secs;
    logic [7:0]  rate;
    logic        sec_tick;

    modport master (
        output pulse, secondclk,
        input  total_steps, dist_tenths, early_secs, high_secs, rate, sec_tick
    );

    modport slave (
        input  pulse, secondclk,
        output total_steps, dist_tenths, early_secs, high_secs, rate, sec_tick
    );
endinterface

// File: rtl/activity_tracker.sv
// Step/second statistics for the tracker display. The step pulse and the
// 1 Hz level are both sampled on clk and edge-detected; nothing runs on a derived clock.
module activity_tracker #(
    parameter int unsigned STEP_MAX        = 9999,
    parameter int unsigned STEPS_PER_TENTH = 200,
    parameter int unsigned DIST_MAX        = 99,
    parameter int unsigned EARLY_SECS      = 9,
    parameter int unsigned EARLY_RATE      = 32,
    parameter int unsigned HIGH_RATE       = 64,
    parameter int unsigned HIGH_DUR        = 60
) (
    input logic               clk,
    input logic               rst_n,
    activity_tracker_if.slave bus
);
    localparam logic [13:0] STEP_M  = 14'(STEP_MAX);
    localparam logic [7:0]  SPT_M1  = 8'(STEPS_PER_TENTH - 1);
    localparam logic [6:0]  DIST_M  = 7'(DIST_MAX);
    localparam logic [3:0]  EARLY_N = 4'(EARLY_SECS);
    localparam logic [7:0]  EARLY_R = 8'(EARLY_RATE);
    localparam logic [7:0]  HIGH_R  = 8'(HIGH_RATE);
    localparam logic [6:0]  DUR_N   = 7'(HIGH_DUR);

    typedef enum logic [1:0] {IDLE, RUN, HIGH} state_t;

    state_t      state;
    logic        s1, s2, s3, q1, q2;
    logic [13:0] total_steps;
    logic [6:0]  dist_tenths;
    logic [3:0]  early_secs;
    logic [15:0] high_secs;
    logic [7:0]  rate;
    logic        sec_tick;
    logic [7:0]  cur_cnt, dist_acc, close_cnt;
    logic [3:0]  sec_num;
    logic [6:0]  run_len;
    logic [16:0] hs_sum;
    logic [15:0] hs_add, hs_inc;
    logic        step_evt, sec_evt, q_high;

    assign step_evt = s2 & ~s3;
    assign sec_evt  = q1 & ~q2;

    // A step coinciding with the boundary belongs to the second being closed.
    always_comb begin
        close_cnt = cur_cnt;
        if (step_evt && cur_cnt != 8'hFF) close_cnt = cur_cnt + 8'd1;
        q_high = close_cnt > HIGH_R;
        hs_sum = {1'b0, high_secs} + 17'(HIGH_DUR);
        hs_add = hs_sum[16] ? 16'hFFFF : hs_sum[15:0];
        hs_inc = (high_secs == 16'hFFFF) ? high_secs : high_secs + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            {s1, s2, s3, q1, q2} <= '0;
            total_steps <= '0;
            dist_tenths <= '0;
            early_secs  <= '0;
            high_secs   <= '0;
            rate        <= '0;
            sec_tick    <= 1'b0;
            cur_cnt     <= '0;
            dist_acc    <= '0;
            sec_num     <= '0;
            run_len     <= '0;
            state       <= IDLE;
        end else begin
            s1 <= bus.pulse;
            s2 <= s1;
            s3 <= s2;
            q1 <= bus.secondclk;
            q2 <= q1;
            sec_tick <= sec_evt;

            if (step_evt) begin
                if (total_steps != STEP_M) total_steps <= total_steps + 14'd1;
                // Distance freezes entirely once the display maximum is reached.
                if (dist_tenths != DIST_M) begin
                    if (dist_acc == SPT_M1) begin
                        dist_acc    <= '0;
                        dist_tenths <= dist_tenths + 7'd1;
                    end else begin
                        dist_acc <= dist_acc + 8'd1;
                    end
                end
            end

            if (sec_evt) begin
                rate    <= close_cnt;
                cur_cnt <= '0;
                if (sec_num != 4'hF) sec_num <= sec_num + 4'd1;
                if (sec_num < EARLY_N && close_cnt > EARLY_R)
                    early_secs <= early_secs + 4'd1;

                case (state)
                    IDLE: if (q_high) begin
                        if (HIGH_DUR == 1) begin
                            state     <= HIGH;
                            high_secs <= hs_add;
                        end else begin
                            state   <= RUN;
                            run_len <= 7'd1;
                        end
                    end
                    RUN: begin
                        if (!q_high) begin
                            state   <= IDLE;
                            run_len <= '0;
                        end else begin
                            run_len <= run_len + 7'd1;
                            if (run_len + 7'd1 == DUR_N) begin
                                state     <= HIGH;
                                high_secs <= hs_add;
                            end
                        end
                    end
                    HIGH: begin
                        if (q_high) begin
                            high_secs <= hs_inc;
                        end else begin
                            state   <= IDLE;
                            run_len <= '0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (step_evt && cur_cnt != 8'hFF) begin
                cur_cnt <= cur_cnt + 8'd1;
            end
        end
    end

    assign bus.total_steps = total_steps;
    assign bus.dist_tenths = dist_tenths;
    assign bus.early_secs  = early_secs;
    assign bus.high_secs   = high_secs;
    assign bus.rate        = rate;
    assign bus.sec_tick    = sec_tick;
endmodule

// File: tb/tb_activity_tracker.sv
// Directed and randomized stimulus for activity_tracker, checked against a
// model that derives statistics from the list of per-second step counts.
module tb_activity_tracker;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    activity_tracker_if bus();
    activity_tracker dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int failures = 0;

    // Model state: steps since reset, steps in the open second, closed-second counts.
    int m_total;
    int m_cur;
    int m_secs[$];

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int model_early();
        int n = 0;
        for (int i = 0; i < m_secs.size() && i < 9; i++)
            if (m_secs[i] > 32) n++;
        return n;
    endfunction

    // Every qualifying run of at least 60 seconds is credited for its full length.
    function automatic int model_high();
        int hs = 0;
        int run = 0;
        foreach (m_secs[i]) begin
            if (m_secs[i] > 64) run++;
            else begin
                if (run >= 60) hs += run;
                run = 0;
            end
        end
        if (run >= 60) hs += run;
        return imin(hs, 65535);
    endfunction

    function automatic int model_rate();
        return (m_secs.size() == 0) ? 0 : m_secs[m_secs.size()-1];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".total"}, 32'(bus.total_steps), imin(m_total, 9999));
        chk({tag, ".dist"},  32'(bus.dist_tenths), imin(m_total / 200, 99));
        chk({tag, ".early"}, 32'(bus.early_secs),  model_early());
        chk({tag, ".high"},  32'(bus.high_secs),   model_high());
        chk({tag, ".rate"},  32'(bus.rate),        model_rate());
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".total"}, 32'(bus.total_steps), 0);
        chk({tag, ".dist"},  32'(bus.dist_tenths), 0);
        chk({tag, ".early"}, 32'(bus.early_secs),  0);
        chk({tag, ".high"},  32'(bus.high_secs),   0);
        chk({tag, ".rate"},  32'(bus.rate),        0);
        chk({tag, ".tick"},  32'(bus.sec_tick),    0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_total = 0;
        m_cur = 0;
        m_secs.delete();
    endtask

    task automatic step(input int hi, input int lo);
        bus.pulse = 1'b1;
        m_total++;
        m_cur++;
        repeat (hi) @(negedge clk);
        bus.pulse = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    // Pulse rise sampled at edge N; the count must move at N+2, not N+1.
    task automatic step_timed();
        bus.pulse = 1'b1;
        m_total++;
        m_cur++;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("step_lat_n1", 32'(bus.total_steps), imin(m_total - 1, 9999));
        @(posedge clk); #1;
        chk("step_lat_n2", 32'(bus.total_steps), imin(m_total, 9999));
        @(negedge clk);
        bus.pulse = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic sec_edge();
        bus.secondclk = 1'b1;
        m_secs.push_back(imin(m_cur, 255));
        m_cur = 0;
        @(posedge clk); #1;
        chk("tick_m", 32'(bus.sec_tick), 0);
        @(posedge clk); #1;
        chk("tick_m1", 32'(bus.sec_tick), 1);
        chk("rate_m1", 32'(bus.rate), model_rate());
        @(posedge clk); #1;
        chk("tick_m2", 32'(bus.sec_tick), 0);
        @(negedge clk);
        bus.secondclk = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic second_of(input int n, input string tag);
        for (int i = 0; i < n; i++) step(3, 3);
        sec_edge();
        check_all(tag);
    endtask

    initial begin
        int early_pat[12];
        bus.pulse = 1'b0;
        bus.secondclk = 1'b0;
        m_total = 0;
        m_cur = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_zero("reset");

        // Step count and distance with exact latency on every step.
        for (int i = 0; i < 450; i++) step_timed();
        chk("steps450.total", 32'(bus.total_steps), 450);
        chk("steps450.dist",  32'(bus.dist_tenths), 2);
        check_all("steps450");

        // Early activity over the first seconds after reset.
        do_reset();
        early_pat = '{33, 32, 40, 50, 50, 50, 50, 50, 50, 50, 50, 50};
        foreach (early_pat[i]) second_of(early_pat[i], "early");
        chk("early.count", 32'(bus.early_secs), 8);
        chk("early.rate",  32'(bus.rate), 50);

        // Step landing in the same cycle as the second boundary.
        do_reset();
        for (int i = 0; i < 10; i++) step(3, 3);
        bus.pulse = 1'b1;
        m_total++;
        m_cur++;
        @(negedge clk);
        bus.secondclk = 1'b1;
        m_secs.push_back(imin(m_cur, 255));
        m_cur = 0;
        repeat (2) @(negedge clk);
        bus.pulse = 1'b0;
        chk("simul.rate", 32'(bus.rate), 11);
        chk("simul.tick", 32'(bus.sec_tick), 1);
        repeat (2) @(negedge clk);
        bus.secondclk = 1'b0;
        repeat (3) @(negedge clk);
        check_all("simul");
        second_of(5, "simul_next");
        chk("simul_next.rate", 32'(bus.rate), 5);

        // Randomized seconds with random step spacing.
        do_reset();
        for (int s = 0; s < 8; s++) begin
            int n;
            n = $urandom_range(0, 80);
            for (int i = 0; i < n; i++) step(3 + $urandom_range(0, 2), 3 + $urandom_range(0, 2));
            sec_edge();
            check_all("rand");
        end

        // High-activity threshold.
        do_reset();
        for (int s = 0; s < 59; s++) second_of(65, "high");
        chk("high59", 32'(bus.high_secs), 0);
        second_of(65, "high");
        chk("high60", 32'(bus.high_secs), 60);
        second_of(65, "high");
        second_of(65, "high");
        chk("high62", 32'(bus.high_secs), 62);
        second_of(64, "high");
        chk("high_drop", 32'(bus.high_secs), 62);

        // Saturation of steps and distance.
        while (m_total < 10005) step(3, 3);
        check_all("sat");
        chk("sat.total", 32'(bus.total_steps), 9999);
        chk("sat.dist",  32'(bus.dist_tenths), 50);

        // Reset in the middle of a run with a partial second pending.
        do_reset();
        for (int s = 0; s < 3; s++) second_of(65, "pre_rst");
        for (int i = 0; i < 30; i++) step(3, 3);
        do_reset();
        check_zero("midreset");
        for (int s = 0; s < 10; s++) second_of(40, "post_rst");
        chk("post_rst.early", 32'(bus.early_secs), 9);
        chk("post_rst.high",  32'(bus.high_secs), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/activity_tracker.md
# activity_tracker

Consumes the 1 Hz second clock from the clock divider and the raw step pulse from the pedometer input, and maintains the tracker statistics shown on the seven-segment display: total steps, distance, early-activity seconds, high-activity time and last-second step rate. The block runs entirely on the 100 MHz system clock. It treats the divider's toggling second clock as a level and edge-detects it, so no logic runs on a derived clock.

## Interface
- STEP_MAX, 9999: saturation value of total_steps.
- STEPS_PER_TENTH, 200: steps per 0.1 mile of distance.
- DIST_MAX, 99: saturation value of dist_tenths (9.9 mi).
- EARLY_SECS, 9: number of seconds from reset in which early activity is scored.
- EARLY_RATE, 32: a second scores early activity when its step count is strictly greater than this.
- HIGH_RATE, 64: a second qualifies as high activity when its step count is strictly greater than this.
- HIGH_DUR, 60: consecutive qualifying seconds needed before high-activity time is credited.

- clk  in  1  system clock, 100 MHz
- rst_n  in  1  synchronous, active-low reset
- pulse  in  1  step input, asynchronous level; already debounced; each level is stable for at least 3 clk cycles
- secondclk  in  1  toggling 1 Hz level from the divider; each rising edge is a second boundary
- total_steps  out  14  total steps, saturating at STEP_MAX
- dist_tenths  out  7  distance in 0.1 mi units, saturating at DIST_MAX
- early_secs  out  4  count of scored early seconds, range 0..EARLY_SECS
- high_secs  out  16  credited high-activity seconds, saturating at 65535
- rate  out  8  step count of the last completed second, saturating at 255
- sec_tick  out  1  one-cycle strobe, high in the cycle after a second boundary is processed

## Operation
- **Step path.** pulse passes through a 2-FF synchronizer (s1, s2) and a delay register s3. step_evt = s2 & ~s3. There is exactly one step_evt per rising edge of pulse.
- **Second path.** secondclk is registered into q1 and q2. sec_evt = q1 & ~q2.
- **On step_evt:**
  - total_steps increments, holding at STEP_MAX once reached.
  - cur_cnt increments, saturating at 255.
  - dist_acc increments. When dist_acc reaches STEPS_PER_TENTH, it clears and dist_tenths increments. Once dist_tenths is at DIST_MAX, both dist_acc and dist_tenths hold.
- **On sec_evt, with closing count c:**
  - c = cur_cnt, plus 1 (saturating) if step_evt is high in the same cycle.
  - rate <= c.
  - cur_cnt <= 0.
  - sec_num increments, saturating at 15.
  - If sec_num < EARLY_SECS and c > EARLY_RATE, early_secs increments.
  - The high-activity FSM advances with q = (c > HIGH_RATE).
- **High-activity FSM** (run_len is 7 bits):
  - IDLE: if q, go to RUN with run_len = 1; otherwise stay.
  - RUN: if !q, go to IDLE with run_len = 0. If q and run_len + 1 == HIGH_DUR, go to HIGH and add HIGH_DUR to high_secs (saturating). Otherwise run_len increments.
  - HIGH: if q, high_secs increments (saturating). If !q, go to IDLE with run_len = 0. Credited time is never removed.
  - With HIGH_DUR == 1, the IDLE transition on q goes directly to HIGH and credits 1.
- **Simultaneous step_evt and sec_evt:** the step counts toward total_steps and toward the closing second. The new second starts at 0.
- **Reset:**
  - All outputs, cur_cnt, dist_acc, sec_num and run_len go to 0.
  - The FSM goes to IDLE.
  - Synchronizer and edge registers go to 0. A pulse or secondclk level that is already high at reset release therefore produces one event 2 cycles later.
  - Reset asserted mid-second discards the partial count. The first second after reset is sec_num 0, even if it is partial.

## Timing
- pulse first sampled high at clk edge N: total_steps, cur_cnt and dist_acc update at edge N+2.
- secondclk first sampled high at edge M: rate, early_secs, high_secs and the FSM update at edge M+1. sec_tick is high in the cycle following edge M+1.
- All outputs are registered. There are no combinational input-to-output paths.
- Throughput is at most one step per 6 clk cycles, set by the pulse stability rule. No back-pressure.

## Test plan
- **Step count and distance.** Reset, then 450 pulses with no second edges. Required: total_steps = 450, dist_tenths = 2, and each increment lands exactly 2 edges after the sampled rise.
- **Saturation.** Preload by driving 10005 pulses. Required: total_steps holds at 9999 and dist_tenths = 50.
- **Early activity.** For 12 seconds, drive 33, 32, 40, then repeating 50 steps per second. Required: early_secs = 8 (seconds 0 and 2..8 score) and rate = 50.
- **High-activity threshold.** Drive 65 steps per second for 59 seconds. Required: high_secs = 0 and the FSM is in RUN. One more second: high_secs = 60. Two more: 62. Then one second at 64 steps: FSM is in IDLE and high_secs stays at 62.
- **Simultaneous events.** A step_evt lands in the same cycle as sec_evt with cur_cnt = 10. Required: rate = 11, and the next second starts at 0.
- **Reset mid-operation.** Assert rst_n = 0 for 1 cycle during the RUN state with 30 steps pending. Required: all outputs 0, FSM in IDLE, and the following seconds counted from sec_num 0.
